posit_add_arbiter: RTL and testbench
====================================

// Module: posit_add_arbiter
// PURPOSE
// - Shares one pipelined posit adder (32-bit, es=3, start/done, fixed latency) among NREQ requesters.
// - Round-robin issue of at most one add per cycle; each request carries a requester ID down a tag
//   pipeline aligned with the adder, so the result is routed back to the requester that issued it.
// - Sits between the PairHMM posit datapath lanes and the single shared adder instance.
// PARAMETERS
// - NREQ    4   number of requesters (>=2)
// - N       32  posit width
// - ES      3   posit exponent size
// - ADD_LAT 4   adder latency: start in cycle t gives done in cycle t+ADD_LAT
// PORTS
// - clk         in   1        system clock; all logic is rising-edge
// - reset       in   1        synchronous, active-high reset
// - req_valid   in   NREQ     per-requester operation valid
// - req_ready   out  NREQ     one-hot grant; the op is accepted when valid&ready
// - req_in1     in   NREQ*N   operand A; requester i occupies bits [i*N +: N]
// - req_in2     in   NREQ*N   operand B; same packing as req_in1
// - rsp_valid   out  NREQ     one-hot; result belongs to requester i
// - rsp_result  out  N        sum, shared by all requesters
// - rsp_inf     out  1        adder inf flag
// - rsp_zero    out  1        adder zero flag
// - add_in1     out  N        to adder in1
// - add_in2     out  N        to adder in2
// - add_start   out  1        to adder start
// - add_result  in   N        from adder result
// - add_inf     in   1        from adder inf
// - add_zero    in   1        from adder zero
// - add_done    in   1        from adder done
// - busy        out  1        any op in flight, or any req_valid high
// - inflight    out  $clog2(ADD_LAT+1)  count of issued ops whose results are not yet returned
// - proto_err   out  1        sticky error flag; cleared only by reset
// BEHAVIOUR
// - Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_inf=0, rsp_zero=0, add_start=0,
//   add_in1=0, add_in2=0, inflight=0, proto_err=0, RR pointer=0, all tags invalid.
// - Grant (combinational from registered pointer):
//   - pick the first i with req_valid[i], searching ptr, ptr+1, ... mod NREQ;
//   - req_ready is one-hot at that i, or 0 if no req_valid.
//   - req_ready is 0 whenever reset is high.
// - Issue register: on a handshake at i, register add_in1/add_in2 from slot i, set add_start=1
//   for exactly one cycle, set ptr <= (i+1) mod NREQ, and push tag {valid=1, id=i}.
//   - With no handshake: add_start=0, ptr is held, push tag valid=0.
// - Throughput: one issue per cycle. The adder never stalls, so there is no back-pressure on results.
// - Tag pipe: ADD_LAT-deep shift register aligned so the tag exits in the cycle add_done is expected.
// - Result register (1 cycle after add_done):
//   - exiting tag valid & add_done: rsp_valid=onehot(id), rsp_result/inf/zero <= adder outputs.
//   - otherwise rsp_valid=0; rsp_result/inf/zero hold their previous values.
// - End-to-end latency: handshake edge -> rsp_valid = ADD_LAT+2 cycles.
// - inflight: +1 on issue, -1 when a valid tag exits; a same-cycle issue and retire leaves it unchanged.
//   It never exceeds ADD_LAT.
// - proto_err set when either:
//   - a valid tag exits with add_done=0, or
//   - add_done=1 with an invalid exiting tag, except in the first ADD_LAT cycles after reset deasserts.
//   - In the second case the stray result is dropped (rsp_valid stays 0).
// - Reset mid-operation: all tags are flushed and the pending results discarded; rsp_valid is never
//   asserted for ops issued before reset.
// - Simultaneous events: issue, retire and rsp on the same cycle are independent; no bubbles are inserted.
// STRUCTURE
// - Package posit_pkg:
//   - localparams POSIT_N=32, POSIT_ES=3, POSIT_ADD_LAT=4;
//   - typedef posit_t (logic [N-1:0]);
//   - typedef add_tag_t struct {valid, id[$clog2(NREQ)-1:0]}.
// - Sub-module posit_tag_pipe: parameterised-depth shift register of add_tag_t with synchronous clear.
// - The top level holds the RR arbiter, issue and result registers, the inflight counter and error logic.
// TESTING
// - Bench pairs this block with a behavioural adder model of latency ADD_LAT, plus one run against
//   positadd_4_es3.
// - Single op: req0 in1=0x2C6B443B, in2=0xCB66FBF9 -> add_start 1 cycle later;
//   rsp_valid=4'b0001, rsp_result=0xCD039A10 at ADD_LAT+2 cycles.
// - All four requesters valid continuously from ptr=0:
//   - grants 0,1,2,3,0,... one per cycle;
//   - rsp_valid sequence 0001,0010,0100,1000 on back-to-back cycles;
//   - inflight saturates at 4.
// - Fairness: req1 and req3 held valid with ptr=2 -> grants 3,1,3,1; req0/req2 never granted.
// - Reset asserted 2 cycles after 3 issues:
//   - no rsp_valid afterwards; inflight=0;
//   - late add_done pulses are ignored and proto_err stays 0.
// - Fault injection:
//   - model suppresses one add_done -> proto_err=1 next cycle and stays 1 until reset;
//   - a spurious add_done with no tag -> proto_err=1, rsp_valid=0.
// - Idle: no req_valid for 10 cycles -> add_start=0, busy=0, ptr unchanged.

Source files
------------

// File: rtl/posit_pkg.sv
// posit_pkg: shared types and defaults for the posit adder-sharing slice.
//   POSIT_N / POSIT_ES / POSIT_ADD_LAT : default posit width, exponent size and adder latency
//   POSIT_NREQ                         : largest requester count the tag id can encode
//   posit_t                            : one posit word
//   add_tag_t                          : requester id travelling alongside an issued add
package posit_pkg;

    localparam int unsigned POSIT_N       = 32;
    localparam int unsigned POSIT_ES      = 3;
    localparam int unsigned POSIT_ADD_LAT = 4;
    localparam int unsigned POSIT_NREQ    = 4;
    localparam int unsigned TAG_ID_W      = $clog2(POSIT_NREQ);

    typedef logic [POSIT_N-1:0] posit_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } add_tag_t;

endpackage

// File: rtl/posit_tag_pipe.sv
// posit_tag_pipe: DEPTH-stage shift register of add_tag_t with synchronous clear.
//   clk   : rising-edge clock
//   clr   : synchronous clear, invalidates every stage
//   din   : tag entering stage 0
//   dout  : tag in the last stage
//   dnext : tag that becomes dout after the next edge
module posit_tag_pipe
    import posit_pkg::*;
#(
    parameter int unsigned DEPTH = POSIT_ADD_LAT
) (
    input  logic     clk,
    input  logic     clr,
    input  add_tag_t din,
    output add_tag_t dout,
    output add_tag_t dnext
);

    add_tag_t q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned k = 0; k < DEPTH; k++) q[k] <= '0;
        end else begin
            q[0] <= din;
            for (int unsigned k = 1; k < DEPTH; k++) q[k] <= q[k-1];
        end
    end

    assign dout = q[DEPTH-1];

    generate
        if (DEPTH > 1) begin : g_deep
            assign dnext = q[DEPTH-2];
        end else begin : g_single
            assign dnext = din;
        end
    endgenerate

endmodule

// File: rtl/posit_add_arbiter.sv
// posit_add_arbiter: round-robin sharing of one fixed-latency pipelined posit adder.
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        : per-requester handshake, ready is a one-hot grant
//   req_in1/req_in2            : operands, requester i at [i*N +: N]
//   rsp_valid                  : one-hot owner of rsp_result/rsp_inf/rsp_zero
//   add_in1/add_in2/add_start  : issue side of the shared adder
//   add_result/inf/zero/done   : return side of the shared adder
//   busy, inflight, proto_err  : status; proto_err is sticky until reset
module posit_add_arbiter
    import posit_pkg::*;
#(
    parameter int unsigned NREQ    = POSIT_NREQ,
    parameter int unsigned N       = POSIT_N,
    parameter int unsigned ES      = POSIT_ES,
    parameter int unsigned ADD_LAT = POSIT_ADD_LAT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*N-1:0]            req_in1,
    input  logic [NREQ*N-1:0]            req_in2,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [N-1:0]                 rsp_result,
    output logic                         rsp_inf,
    output logic                         rsp_zero,
    output logic [N-1:0]                 add_in1,
    output logic [N-1:0]                 add_in2,
    output logic                         add_start,
    input  logic [N-1:0]                 add_result,
    input  logic                         add_inf,
    input  logic                         add_zero,
    input  logic                         add_done,
    output logic                         busy,
    output logic [$clog2(ADD_LAT+1)-1:0] inflight,
    output logic                         proto_err
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(ADD_LAT+1);

    generate
        if (NREQ < 2 || NREQ > POSIT_NREQ || ES >= N || ADD_LAT < 1) begin : g_cfg_check
            $error("posit_add_arbiter: unsupported parameter combination");
        end
    endgenerate

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          gany;
    logic          hs;
    int unsigned   idx;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        gidx = '0;
        gany = 1'b0;
        idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gany && req_valid[idx]) begin
                gany = 1'b1;
                gidx = PW'(idx);
            end
        end
    end

    assign hs        = gany & ~reset;
    assign req_ready = hs ? (NREQ'(1) << gidx) : '0;

    add_tag_t issue_tag;
    add_tag_t exit_tag;
    add_tag_t pre_exit_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            add_start <= 1'b0;
            add_in1   <= '0;
            add_in2   <= '0;
            issue_tag <= '0;
        end else begin
            add_start       <= hs;
            issue_tag.valid <= hs;
            issue_tag.id    <= TAG_ID_W'(gidx);
            if (hs) begin
                add_in1 <= req_in1[int'(gidx)*N +: N];
                add_in2 <= req_in2[int'(gidx)*N +: N];
                ptr     <= (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
            end
        end
    end

    // issue_tag sits alongside add_start; ADD_LAT further stages line it up with add_done.
    posit_tag_pipe #(
        .DEPTH (ADD_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .clr   (reset),
        .din   (issue_tag),
        .dout  (exit_tag),
        .dnext (pre_exit_tag)
    );

    // Stray done pulses right after reset belong to ops flushed by that reset.
    logic [CW-1:0] guard;

    always_ff @(posedge clk) begin
        if (reset)              guard <= CW'(ADD_LAT);
        else if (guard != '0)   guard <= guard - CW'(1);
    end

    logic retire;
    logic lost;
    logic stray;

    assign retire = exit_tag.valid & add_done;
    assign lost   = exit_tag.valid & ~add_done;
    assign stray  = ~exit_tag.valid & add_done & (guard == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_inf    <= 1'b0;
            rsp_zero   <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            rsp_valid <= retire ? (NREQ'(1) << exit_tag.id) : '0;
            if (retire) begin
                rsp_result <= add_result;
                rsp_inf    <= add_inf;
                rsp_zero   <= add_zero;
            end
            if (lost || stray) proto_err <= 1'b1;
        end
    end

    // An op leaves the count when its tag moves into the exit stage, so the
    // add_done cycle itself is not counted and the total tops out at ADD_LAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({hs, pre_exit_tag.valid})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign busy = (|req_valid) | (inflight != '0) | exit_tag.valid;

endmodule

// File: tb/tb_posit_add_arbiter.sv
module tb_posit_add_arbiter;

    localparam int NREQ    = 4;
    localparam int N       = 32;
    localparam int ES      = 3;
    localparam int ADD_LAT = 4;
    localparam int CW      = $clog2(ADD_LAT+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid;
    logic [NREQ*N-1:0] req_in1, req_in2;
    logic [N-1:0]      rsp_result, add_in1, add_in2, add_result;
    logic              rsp_inf, rsp_zero, add_start, add_inf, add_zero, add_done;
    logic              busy, proto_err;
    logic [CW-1:0]     inflight;

    posit_add_arbiter #(
        .NREQ    (NREQ),
        .N       (N),
        .ES      (ES),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_inf    (rsp_inf),
        .rsp_zero   (rsp_zero),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .add_start  (add_start),
        .add_result (add_result),
        .add_inf    (add_inf),
        .add_zero   (add_zero),
        .add_done   (add_done),
        .busy       (busy),
        .inflight   (inflight),
        .proto_err  (proto_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural adder. The known vector uses its true posit sum; other operands
    // get an operand-dependent stand-in (NaR propagates, x + (-x) gives zero).
    function automatic logic [N-1:0] model_sum(input logic [N-1:0] a, input logic [N-1:0] b);
        if (a == 32'h2C6B443B && b == 32'hCB66FBF9) return 32'hCD039A10;
        if (a == 32'h80000000 || b == 32'h80000000) return 32'h80000000;
        return a + b;
    endfunction

    logic [ADD_LAT-1:0] mv = '0;
    logic [N-1:0]       mr [ADD_LAT];
    logic               kill = 1'b0;
    logic               spur = 1'b0;

    always @(posedge clk) begin
        mv    <= {mv[ADD_LAT-2:0], add_start};
        mr[0] <= model_sum(add_in1, add_in2);
        for (int k = 1; k < ADD_LAT; k++) mr[k] <= mr[k-1];
    end

    assign add_result = mr[ADD_LAT-1];
    assign add_inf    = (add_result == 32'h80000000);
    assign add_zero   = (add_result == '0);
    assign add_done   = (mv[ADD_LAT-1] & ~kill) | spur;

    typedef struct {
        int          id;
        logic [N-1:0] res;
        logic        inf;
        logic        zero;
        int          due;
    } exp_t;

    exp_t            sb[$];
    int              cyc     = 0;
    int              mptr    = 0;
    logic [NREQ-1:0] last_gnt;
    logic            prev_hs = 1'b0;
    logic [N-1:0]    prev_a, prev_b;
    logic            exp_err = 1'b0;
    bit              push_en = 1'b1;

    // One clock cycle: check at the negedge, update the model, return #1 after the posedge.
    task automatic tick();
        logic [NREQ-1:0] g;
        exp_t            e;
        int              id;
        @(negedge clk);
        g  = '0;
        id = 0;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g == '0 && req_valid[(mptr+k)%NREQ]) begin
                    id = (mptr + k) % NREQ;
                    g[id] = 1'b1;
                end
            end
        end
        chk("req_ready", req_ready, g);
        chk("add_start", add_start, prev_hs);
        if (prev_hs) begin
            chk("add_in1", add_in1, prev_a);
            chk("add_in2", add_in2, prev_b);
        end
        chk("proto_err", proto_err, exp_err);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", rsp_valid, 64'(1) << e.id);
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_inf", rsp_inf, e.inf);
            chk("rsp_zero", rsp_zero, e.zero);
        end else begin
            chk("rsp_valid_idle", rsp_valid, '0);
        end
        last_gnt = g;
        prev_hs  = (g != '0);
        if (g != '0) begin
            prev_a = req_in1[id*N +: N];
            prev_b = req_in2[id*N +: N];
            if (push_en) begin
                e.id   = id;
                e.res  = model_sum(prev_a, prev_b);
                e.inf  = (e.res == 32'h80000000);
                e.zero = (e.res == '0);
                e.due  = cyc + ADD_LAT + 2;
                sb.push_back(e);
            end
            mptr = (id + 1) % NREQ;
        end
        if (reset) begin
            mptr    = 0;
            exp_err = 1'b0;
            sb.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic [NREQ-1:0] v;
        logic [N-1:0]    a;
        logic [N-1:0]    b;
        logic [NREQ-1:0] exp_rdy;
    } vec_t;

    vec_t            tbl [10];
    logic [NREQ-1:0] gseq [8];

    task automatic drive_ops(input logic [N-1:0] a, input logic [N-1:0] b);
        for (int s = 0; s < NREQ; s++) begin
            req_in1[s*N +: N] = a + N'(s);
            req_in2[s*N +: N] = b - N'(s);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0001, 32'h2C6B443B, 32'hCB66FBF9, 4'b0001};
        tbl[1] = '{4'b0000, 32'h11111111, 32'h22222222, 4'b0000};
        tbl[2] = '{4'b0101, 32'h3F800000, 32'h40000000, 4'b0100};
        tbl[3] = '{4'b0101, 32'h80000000, 32'h5A5A5A5A, 4'b0001};
        tbl[4] = '{4'b1000, 32'h12345678, 32'hEDCBA988, 4'b1000};
        tbl[5] = '{4'b0110, 32'h0BADF00D, 32'h7E57C0DE, 4'b0010};
        tbl[6] = '{4'b0011, 32'h40000000, 32'h40000000, 4'b0001};
        tbl[7] = '{4'b1111, 32'hDEADBEEF, 32'h01234567, 4'b0010};
        tbl[8] = '{4'b1011, 32'h60000000, 32'hA0000000, 4'b1000};
        tbl[9] = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000};

        reset = 1'b1; req_valid = '0; req_in1 = '0; req_in2 = '0;
        @(posedge clk); #1;
        req_valid = '1;
        tick(); tick();
        chk("reset_rsp_valid", rsp_valid, '0);
        chk("reset_rsp_result", rsp_result, '0);
        chk("reset_rsp_flags", {rsp_inf, rsp_zero}, 2'b00);
        chk("reset_add_start", add_start, 1'b0);
        chk("reset_add_in", {add_in1, add_in2}, '0);
        chk("reset_inflight", inflight, '0);
        chk("reset_proto_err", proto_err, 1'b0);
        reset = 1'b0; req_valid = '0;

        // Table of single-cycle grants, walking the pointer from 0.
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].v;
            drive_ops(tbl[i].a, tbl[i].b);
            #1;
            chk("tbl_ready", req_ready, tbl[i].exp_rdy);
            tick();
        end
        req_valid = '0;
        repeat (ADD_LAT + 3) tick();
        chk("tbl_drain", sb.size(), 0);

        // Idle: nothing issued, nothing busy.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_busy", busy, 1'b0);
        end

        // All requesters continuously valid: pointer left at 0 by the table.
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            drive_ops($urandom, $urandom);
            tick();
            gseq[k] = last_gnt;
            chk("rr_inflight", inflight, (k + 1 < ADD_LAT) ? k + 1 : ADD_LAT);
            chk("rr_busy", busy, 1'b1);
        end
        for (int k = 0; k < 8; k++) chk("rr_grant_seq", gseq[k], 4'b0001 << (k % 4));
        req_valid = '0;
        repeat (ADD_LAT + 3) tick();
        chk("rr_drain", sb.size(), 0);
        chk("rr_inflight_end", inflight, '0);

        // Fairness: park the pointer at 2, then only 1 and 3 contend.
        req_valid = 4'b0010;
        drive_ops(32'h01010101, 32'h02020202);
        tick();
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            drive_ops($urandom, $urandom);
            tick();
            gseq[k] = last_gnt;
        end
        chk("fair_0", gseq[0], 4'b1000);
        chk("fair_1", gseq[1], 4'b0010);
        chk("fair_2", gseq[2], 4'b1000);
        chk("fair_3", gseq[3], 4'b0010);
        req_valid = '0;
        repeat (ADD_LAT + 3) tick();

        // Reset two cycles after three issues: those results never appear.
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            drive_ops($urandom, $urandom);
            tick();
        end
        req_valid = '0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset_inflight", inflight, '0);
        repeat (ADD_LAT + 4) tick();
        chk("mid_reset_err", proto_err, 1'b0);

        // Suppressed add_done for a tagged op.
        req_valid = 4'b0001;
        drive_ops(32'h33333333, 32'h44444444);
        push_en = 1'b0;
        tick();
        push_en = 1'b1;
        req_valid = '0;
        repeat (ADD_LAT) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        exp_err = 1'b1;
        repeat (3) tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (ADD_LAT + 1) tick();

        // Spurious add_done with no tag in the exit stage.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        exp_err = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
